decode_stage_hz: RTL and testbench
==================================

# decode_stage_hz

Parametrised MIPS instruction-decode stage with an integrated register file, ID-stage branch/jump resolution, load-use and branch-operand hazard detection, and a stallable/flushable ID/EX pipeline register. It sits between the IF/ID register and the execute stage. It generalises the earlier decode block in two ways:

- register count, data width and control-field widths are parameters;
- the block generates its own stall and forwarding decisions, so the core needs no separate hazard unit.

## Interface
- NB_BITS, 32, data/address width
- NB_REG, 5, register-number width; file holds 2**NB_REG registers
- NB_EXEC, 9, execute-control width
- NB_MEM, 3, memory-control width
- NB_WB, 2, writeback-control width
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_pc  in  NB_BITS  PC+4 of instruction in ID
- i_instr  in  NB_BITS  instruction from IF/ID
- i_wb_data  in  NB_BITS  writeback data
- i_reg_dst  in  NB_REG  writeback register number
- i_wb_rf_webn  in  1  writeback enable (1 = write)
- i_mem_alu_data  in  NB_BITS  ALU result currently held in EX/MEM
- o_id_ex_pc, o_id_ex_rs, o_id_ex_rt, o_id_ex_sgext  out  NB_BITS  registered PC+4, operands, extended immediate
- o_id_ex_rs_num, o_id_ex_rt_num, o_id_ex_rd_num  out  NB_REG  registered register numbers
- o_id_ex_exec  out  NB_EXEC  fields:
  - [8:7] reg_dst: 00 rt, 01 rd, 10 r31
  - [6] alu_src_imm
  - [5] link
  - [4:1] alu_op: 0000 funct, 0001 add, 0010 slt, 0011 and, 0100 or, 0101 xor, 0110 lui
  - [0] zero_ext
- o_id_ex_mem  out  NB_MEM  [2] read, [1] write, [0] word
- o_id_ex_wrback  out  NB_WB  [1] reg_write, [0] mem_to_reg
- o_pc_tgt  out  NB_BITS  redirect target (combinational)
- o_pc_src  out  1  take o_pc_tgt this cycle (combinational)
- o_flush  out  1  zero the IF/ID register (combinational, equals o_pc_src)
- o_stall  out  1  hold PC and IF/ID this cycle (combinational)

## Operation
- **Supported instructions:** R-type ALU, ADDI, SLTI, ANDI, ORI, XORI, LUI, LW, SW, BEQ, BNE, J, JAL, JR, JALR.
  - Unknown opcode decodes as NOP (all control 0).
  - Instruction 0 decodes as NOP.
- **Immediate:** sign-extended; zero-extended when zero_ext=1 (ANDI/ORI/XORI).
- **Register file:**
  - r0 reads 0; writes to r0 are ignored.
  - Same-cycle write/read bypass: if i_wb_rf_webn=1 and i_reg_dst equals the source (≠0), the read returns i_wb_data.
- **Shadow MEM tracking:** each cycle the ID/EX reg_write, mem read bit and destination (after reg_dst mux) are copied into an internal EX/MEM shadow.
- **Source usage:** rt is a used source only for R-type, BEQ, BNE and SW.
- **Load-use stall:** stall when ID/EX is a load with destination ≠0 matching a used ID source.
- **Branch-operand stall:** applies when the ID instruction is BEQ, BNE, JR or JALR. Stall when either:
  - ID/EX writes a register (≠0) matching a source; or
  - the MEM shadow is a load whose destination matches a source.
- **Branch-operand forwarding:** if the MEM shadow is a non-load write whose destination matches a source, that operand is taken from i_mem_alu_data. Otherwise it comes from the register file, with bypass.
- **During a stall:**
  - o_stall=1 and o_pc_src=0;
  - ID/EX loads a bubble: exec, mem and wrback are 0; data fields don't-care but driven 0.
- **Redirect targets** (when not stalled):
  - BEQ/BNE taken: i_pc + (sgext<<2), truncated to NB_BITS.
  - J/JAL: {i_pc[NB_BITS-1:28], instr[25:0], 2'b00}.
  - JR/JALR: rs value.
  - o_flush=o_pc_src.
- **Link:** JAL/JALR set link=1 and reg_write=1. reg_dst is 10 for JAL and 01 for JALR.

## Timing
- Redirect and stall decisions are combinational in the same cycle the instruction is in ID.
- ID/EX outputs update at the next rising edge (1-cycle latency).
- Stall counts:
  - Load followed by a dependent ALU instruction: 1 stall cycle.
  - Branch or JR dependent on an ALU instruction in EX: 1 stall, then forward from MEM.
  - Branch or JR dependent on a load in EX: 2 stalls, then the register-file bypass supplies the value.
- A stall and a redirect are never asserted together.
- Reset (async, active-low), asserted at any time including mid-stall:
  - all ID/EX outputs 0, the shadow cleared and all registers 0, immediately;
  - o_stall, o_pc_src and o_flush follow combinationally from the cleared state.
- After reset release, the first rising edge captures normally.

## Test plan
- **Writeback then use:** write r1=1 (webn=1); next cycle ADDI 0x20240007 -> o_id_ex_rs=1, sgext=7, exec[6]=1, alu_op=0001, wrback=2'b10.
- **Bypass jump:** i_reg_dst=10, i_wb_data=8, webn=1 while JR r10 (0x01400008) is in ID -> o_pc_src=1, o_pc_tgt=8, o_flush=1, o_stall=0.
- **Load-use:** LW r1 (0x8C410004) then ADD r3,r1,r2 -> one cycle o_stall=1 with an ID/EX bubble (exec/mem/wb=0); next edge ADD is issued with rs_num=1.
- **Branch after ADDI:** ADDI r1 then BEQ r1,r2,0x81 -> 1 stall; then o_pc_src=(i_mem_alu_data==r2), o_pc_tgt=i_pc+0x204.
- **Branch after load:** LW r1 then BNE r1,r3 -> 2 stall cycles, then resolution using i_wb_data via bypass.
- **Reset mid-stall:** drive i_rst=0 during a load-use stall -> all outputs 0 asynchronously and o_stall=0; on release, a NOP decodes.

Source files
------------

// File: rtl/decode_stage_hz.sv
// -----------------------------------------------------------------------------
// decode_stage_hz
//
// MIPS instruction-decode stage. Decodes the instruction held in IF/ID, reads
// the register file (with same-cycle writeback bypass), resolves branches and
// jumps in ID, detects load-use and branch-operand hazards, and drives the
// stallable ID/EX pipeline register.
//
// Ports
//   i_clk, i_rst (async, active low)
//   i_pc, i_instr           : PC+4 and instruction of the ID instruction
//   i_wb_data, i_reg_dst,
//   i_wb_rf_webn            : register-file write port (webn = 1 writes)
//   i_mem_alu_data          : ALU result in EX/MEM, used for branch forwarding
//   o_id_ex_*               : registered ID/EX payload and control fields
//   o_pc_tgt, o_pc_src      : redirect target / take-redirect (combinational)
//   o_flush                 : clear IF/ID (same as o_pc_src)
//   o_stall                 : hold PC and IF/ID this cycle
//
// Control-field layout assumes NB_EXEC >= 9, NB_MEM >= 3, NB_WB >= 2 and a
// 32-bit MIPS instruction encoding.
// -----------------------------------------------------------------------------
module decode_stage_hz #(
    parameter int NB_BITS = 32,
    parameter int NB_REG  = 5,
    parameter int NB_EXEC = 9,
    parameter int NB_MEM  = 3,
    parameter int NB_WB   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_pc,
    input  logic [NB_BITS-1:0] i_instr,
    input  logic [NB_BITS-1:0] i_wb_data,
    input  logic [NB_REG-1:0]  i_reg_dst,
    input  logic               i_wb_rf_webn,
    input  logic [NB_BITS-1:0] i_mem_alu_data,
    output logic [NB_BITS-1:0] o_id_ex_pc,
    output logic [NB_BITS-1:0] o_id_ex_rs,
    output logic [NB_BITS-1:0] o_id_ex_rt,
    output logic [NB_BITS-1:0] o_id_ex_sgext,
    output logic [NB_REG-1:0]  o_id_ex_rs_num,
    output logic [NB_REG-1:0]  o_id_ex_rt_num,
    output logic [NB_REG-1:0]  o_id_ex_rd_num,
    output logic [NB_EXEC-1:0] o_id_ex_exec,
    output logic [NB_MEM-1:0]  o_id_ex_mem,
    output logic [NB_WB-1:0]   o_id_ex_wrback,
    output logic [NB_BITS-1:0] o_pc_tgt,
    output logic               o_pc_src,
    output logic               o_flush,
    output logic               o_stall
);

    localparam int N_REGS = 2 ** NB_REG;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_LUI = 4'd6;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [NB_REG-1:0] REG_ZERO = '0;
    localparam logic [NB_REG-1:0] REG_LINK = NB_REG'(31);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [NB_REG-1:0] rs_num;
    logic [NB_REG-1:0] rt_num;
    logic [NB_REG-1:0] rd_num;

    assign opcode = i_instr[31:26];
    assign funct  = i_instr[5:0];
    assign imm    = i_instr[15:0];
    assign rs_num = NB_REG'(i_instr[25:21]);
    assign rt_num = NB_REG'(i_instr[20:16]);
    assign rd_num = NB_REG'(i_instr[15:11]);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NB_BITS-1:0] rf_q [N_REGS];
    logic [NB_BITS-1:0] rf_d [N_REGS];

    logic [NB_BITS-1:0] id_ex_pc_q,     id_ex_pc_d;
    logic [NB_BITS-1:0] id_ex_rs_q,     id_ex_rs_d;
    logic [NB_BITS-1:0] id_ex_rt_q,     id_ex_rt_d;
    logic [NB_BITS-1:0] id_ex_sgext_q,  id_ex_sgext_d;
    logic [NB_REG-1:0]  id_ex_rs_num_q, id_ex_rs_num_d;
    logic [NB_REG-1:0]  id_ex_rt_num_q, id_ex_rt_num_d;
    logic [NB_REG-1:0]  id_ex_rd_num_q, id_ex_rd_num_d;
    logic [NB_EXEC-1:0] id_ex_exec_q,   id_ex_exec_d;
    logic [NB_MEM-1:0]  id_ex_mem_q,    id_ex_mem_d;
    logic [NB_WB-1:0]   id_ex_wb_q,     id_ex_wb_d;

    // Shadow of EX/MEM: enough to know what the instruction now in MEM writes.
    logic               mem_wr_q,  mem_wr_d;
    logic               mem_rd_q,  mem_rd_d;
    logic [NB_REG-1:0]  mem_dst_q, mem_dst_d;

    // ------------------------------------------------------------------
    // Register file: r0 is never written so it stays at its reset value 0.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < N_REGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (i_wb_rf_webn && (i_reg_dst != REG_ZERO)) begin
            rf_d[i_reg_dst] = i_wb_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Reads see a writeback landing in the same cycle.
    logic [NB_BITS-1:0] rs_rf;
    logic [NB_BITS-1:0] rt_rf;

    assign rs_rf = (i_wb_rf_webn && (i_reg_dst == rs_num) && (rs_num != REG_ZERO))
                   ? i_wb_data : rf_q[rs_num];
    assign rt_rf = (i_wb_rf_webn && (i_reg_dst == rt_num) && (rt_num != REG_ZERO))
                   ? i_wb_data : rf_q[rt_num];

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    logic [NB_EXEC-1:0] ctl_exec;
    logic [NB_MEM-1:0]  ctl_mem;
    logic [NB_WB-1:0]   ctl_wb;
    logic               is_beq;
    logic               is_bne;
    logic               is_j;
    logic               is_jr;
    logic               uses_rt;

    always_comb begin
        ctl_exec = '0;
        ctl_mem  = '0;
        ctl_wb   = '0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        uses_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                // The all-zero word is the canonical NOP and writes nothing.
                if (i_instr != '0) begin
                    uses_rt = 1'b1;
                    if (funct == FN_JR) begin
                        is_jr = 1'b1;
                    end else if (funct == FN_JALR) begin
                        is_jr         = 1'b1;
                        ctl_exec[8:7] = DST_RD;
                        ctl_exec[5]   = 1'b1;
                        ctl_wb[1]     = 1'b1;
                    end else begin
                        ctl_exec[8:7] = DST_RD;
                        ctl_wb[1]     = 1'b1;
                    end
                end
            end
            OP_J: begin
                is_j = 1'b1;
            end
            OP_JAL: begin
                is_j          = 1'b1;
                ctl_exec[8:7] = DST_R31;
                ctl_exec[5]   = 1'b1;
                ctl_wb[1]     = 1'b1;
            end
            OP_BEQ: begin
                is_beq  = 1'b1;
                uses_rt = 1'b1;
            end
            OP_BNE: begin
                is_bne  = 1'b1;
                uses_rt = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctl_exec[8:7] = DST_RT;
                ctl_exec[6]   = 1'b1;
                ctl_wb[1]     = 1'b1;
                case (opcode)
                    OP_ADDI: ctl_exec[4:1] = ALU_ADD;
                    OP_SLTI: ctl_exec[4:1] = ALU_SLT;
                    OP_ANDI: begin ctl_exec[4:1] = ALU_AND; ctl_exec[0] = 1'b1; end
                    OP_ORI:  begin ctl_exec[4:1] = ALU_OR;  ctl_exec[0] = 1'b1; end
                    OP_XORI: begin ctl_exec[4:1] = ALU_XOR; ctl_exec[0] = 1'b1; end
                    default: ctl_exec[4:1] = ALU_LUI;
                endcase
            end
            OP_LW: begin
                ctl_exec[6]   = 1'b1;
                ctl_exec[4:1] = ALU_ADD;
                ctl_mem[2]    = 1'b1;
                ctl_mem[0]    = 1'b1;
                ctl_wb[1]     = 1'b1;
                ctl_wb[0]     = 1'b1;
            end
            OP_SW: begin
                uses_rt       = 1'b1;
                ctl_exec[6]   = 1'b1;
                ctl_exec[4:1] = ALU_ADD;
                ctl_mem[1]    = 1'b1;
                ctl_mem[0]    = 1'b1;
            end
            default: ;
        endcase
    end

    logic [NB_BITS-1:0] sgext;
    assign sgext = ctl_exec[0] ? {{(NB_BITS-16){1'b0}}, imm}
                               : {{(NB_BITS-16){imm[15]}}, imm};

    // ------------------------------------------------------------------
    // Hazards and branch resolution
    // ------------------------------------------------------------------
    logic [NB_REG-1:0]  id_ex_dst;
    logic               is_br_op;
    logic               ex_hit;
    logic               mem_hit_rs;
    logic               mem_hit_rt;
    logic               load_use;
    logic               br_stall;
    logic               stall;
    logic               fwd_rs;
    logic               fwd_rt;
    logic [NB_BITS-1:0] rs_br;
    logic [NB_BITS-1:0] rt_br;
    logic               taken;
    logic [NB_BITS-1:0] pc_tgt;

    always_comb begin
        case (id_ex_exec_q[8:7])
            DST_RD:  id_ex_dst = id_ex_rd_num_q;
            DST_R31: id_ex_dst = REG_LINK;
            default: id_ex_dst = id_ex_rt_num_q;
        endcase
    end

    assign is_br_op = is_beq | is_bne | is_jr;

    // Instruction in EX will write a register this ID instruction reads.
    assign ex_hit = (id_ex_dst != REG_ZERO) &&
                    ((id_ex_dst == rs_num) || (uses_rt && (id_ex_dst == rt_num)));

    assign mem_hit_rs = mem_wr_q && (mem_dst_q != REG_ZERO) && (mem_dst_q == rs_num);
    assign mem_hit_rt = mem_wr_q && (mem_dst_q != REG_ZERO) && uses_rt && (mem_dst_q == rt_num);

    assign load_use = id_ex_mem_q[2] && ex_hit;

    // Branch operands are compared in ID, so even an ALU result in EX is too
    // late; a load in MEM is also too late and must wait for writeback.
    assign br_stall = is_br_op &&
                      ((id_ex_wb_q[1] && ex_hit) ||
                       (mem_rd_q && (mem_hit_rs || mem_hit_rt)));

    assign stall = load_use | br_stall;

    assign fwd_rs = mem_hit_rs && !mem_rd_q;
    assign fwd_rt = mem_hit_rt && !mem_rd_q;
    assign rs_br  = fwd_rs ? i_mem_alu_data : rs_rf;
    assign rt_br  = fwd_rt ? i_mem_alu_data : rt_rf;

    assign taken = (is_beq && (rs_br == rt_br)) || (is_bne && (rs_br != rt_br));

    always_comb begin
        if (is_j) begin
            pc_tgt = {i_pc[NB_BITS-1:28], i_instr[25:0], 2'b00};
        end else if (is_jr) begin
            pc_tgt = rs_br;
        end else begin
            pc_tgt = i_pc + (sgext << 2);
        end
    end

    assign o_pc_tgt = pc_tgt;
    assign o_pc_src = !stall && (is_j || is_jr || taken);
    assign o_flush  = o_pc_src;
    assign o_stall  = stall;

    // ------------------------------------------------------------------
    // ID/EX next state: a stall inserts an all-zero bubble.
    // ------------------------------------------------------------------
    always_comb begin
        id_ex_pc_d     = '0;
        id_ex_rs_d     = '0;
        id_ex_rt_d     = '0;
        id_ex_sgext_d  = '0;
        id_ex_rs_num_d = '0;
        id_ex_rt_num_d = '0;
        id_ex_rd_num_d = '0;
        id_ex_exec_d   = '0;
        id_ex_mem_d    = '0;
        id_ex_wb_d     = '0;
        if (!stall) begin
            id_ex_pc_d     = i_pc;
            id_ex_rs_d     = rs_rf;
            id_ex_rt_d     = rt_rf;
            id_ex_sgext_d  = sgext;
            id_ex_rs_num_d = rs_num;
            id_ex_rt_num_d = rt_num;
            id_ex_rd_num_d = rd_num;
            id_ex_exec_d   = ctl_exec;
            id_ex_mem_d    = ctl_mem;
            id_ex_wb_d     = ctl_wb;
        end
        mem_wr_d  = id_ex_wb_q[1];
        mem_rd_d  = id_ex_mem_q[2];
        mem_dst_d = id_ex_dst;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            id_ex_pc_q     <= '0;
            id_ex_rs_q     <= '0;
            id_ex_rt_q     <= '0;
            id_ex_sgext_q  <= '0;
            id_ex_rs_num_q <= '0;
            id_ex_rt_num_q <= '0;
            id_ex_rd_num_q <= '0;
            id_ex_exec_q   <= '0;
            id_ex_mem_q    <= '0;
            id_ex_wb_q     <= '0;
            mem_wr_q       <= 1'b0;
            mem_rd_q       <= 1'b0;
            mem_dst_q      <= '0;
        end else begin
            id_ex_pc_q     <= id_ex_pc_d;
            id_ex_rs_q     <= id_ex_rs_d;
            id_ex_rt_q     <= id_ex_rt_d;
            id_ex_sgext_q  <= id_ex_sgext_d;
            id_ex_rs_num_q <= id_ex_rs_num_d;
            id_ex_rt_num_q <= id_ex_rt_num_d;
            id_ex_rd_num_q <= id_ex_rd_num_d;
            id_ex_exec_q   <= id_ex_exec_d;
            id_ex_mem_q    <= id_ex_mem_d;
            id_ex_wb_q     <= id_ex_wb_d;
            mem_wr_q       <= mem_wr_d;
            mem_rd_q       <= mem_rd_d;
            mem_dst_q      <= mem_dst_d;
        end
    end

    assign o_id_ex_pc     = id_ex_pc_q;
    assign o_id_ex_rs     = id_ex_rs_q;
    assign o_id_ex_rt     = id_ex_rt_q;
    assign o_id_ex_sgext  = id_ex_sgext_q;
    assign o_id_ex_rs_num = id_ex_rs_num_q;
    assign o_id_ex_rt_num = id_ex_rt_num_q;
    assign o_id_ex_rd_num = id_ex_rd_num_q;
    assign o_id_ex_exec   = id_ex_exec_q;
    assign o_id_ex_mem    = id_ex_mem_q;
    assign o_id_ex_wrback = id_ex_wb_q;

endmodule

// File: tb/tb_decode_stage_hz.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_hz
//
// Directed bench for decode_stage_hz: a table of single-instruction decode
// vectors (each isolated by NOPs) plus hand-written multi-cycle sequences for
// writeback bypass, load-use, branch-operand stalls/forwarding and reset.
// -----------------------------------------------------------------------------
module tb_decode_stage_hz;

    localparam int NB_BITS = 32;
    localparam int NB_REG  = 5;
    localparam int NB_EXEC = 9;
    localparam int NB_MEM  = 3;
    localparam int NB_WB   = 2;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [NB_BITS-1:0] i_pc = '0;
    logic [NB_BITS-1:0] i_instr = '0;
    logic [NB_BITS-1:0] i_wb_data = '0;
    logic [NB_REG-1:0]  i_reg_dst = '0;
    logic               i_wb_rf_webn = 1'b0;
    logic [NB_BITS-1:0] i_mem_alu_data = '0;
    logic [NB_BITS-1:0] o_id_ex_pc;
    logic [NB_BITS-1:0] o_id_ex_rs;
    logic [NB_BITS-1:0] o_id_ex_rt;
    logic [NB_BITS-1:0] o_id_ex_sgext;
    logic [NB_REG-1:0]  o_id_ex_rs_num;
    logic [NB_REG-1:0]  o_id_ex_rt_num;
    logic [NB_REG-1:0]  o_id_ex_rd_num;
    logic [NB_EXEC-1:0] o_id_ex_exec;
    logic [NB_MEM-1:0]  o_id_ex_mem;
    logic [NB_WB-1:0]   o_id_ex_wrback;
    logic [NB_BITS-1:0] o_pc_tgt;
    logic               o_pc_src;
    logic               o_flush;
    logic               o_stall;

    decode_stage_hz #(
        .NB_BITS (NB_BITS),
        .NB_REG  (NB_REG),
        .NB_EXEC (NB_EXEC),
        .NB_MEM  (NB_MEM),
        .NB_WB   (NB_WB)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pc           (i_pc),
        .i_instr        (i_instr),
        .i_wb_data      (i_wb_data),
        .i_reg_dst      (i_reg_dst),
        .i_wb_rf_webn   (i_wb_rf_webn),
        .i_mem_alu_data (i_mem_alu_data),
        .o_id_ex_pc     (o_id_ex_pc),
        .o_id_ex_rs     (o_id_ex_rs),
        .o_id_ex_rt     (o_id_ex_rt),
        .o_id_ex_sgext  (o_id_ex_sgext),
        .o_id_ex_rs_num (o_id_ex_rs_num),
        .o_id_ex_rt_num (o_id_ex_rt_num),
        .o_id_ex_rd_num (o_id_ex_rd_num),
        .o_id_ex_exec   (o_id_ex_exec),
        .o_id_ex_mem    (o_id_ex_mem),
        .o_id_ex_wrback (o_id_ex_wrback),
        .o_pc_tgt       (o_pc_tgt),
        .o_pc_src       (o_pc_src),
        .o_flush        (o_flush),
        .o_stall        (o_stall)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] n, input logic [31:0] v);
        i_instr      = '0;
        i_reg_dst    = n;
        i_wb_data    = v;
        i_wb_rf_webn = 1'b1;
        step();
        i_wb_rf_webn = 1'b0;
    endtask

    task automatic nops(input int n);
        i_instr = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [8:0]  exec;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic [31:0] sgext;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic        src;
        logic [31:0] tgt;
    } vec_t;

    localparam int NVEC = 18;
    localparam logic [31:0] VPC = 32'h0040_0010;
    vec_t vecs [NVEC];

    initial begin
        // Register contents during the table: r1=0x11 r2=0x22 r3=0x22 r4=0x1000
        vecs[0]  = '{32'h0022_2820, 9'h080, 3'b000, 2'b10, 32'h0000_2820, 32'h11, 32'h22, 1'b0, 32'h0};          // ADD r5,r1,r2
        vecs[1]  = '{32'h2026_FFFF, 9'h042, 3'b000, 2'b10, 32'hFFFF_FFFF, 32'h11, 32'h0, 1'b0, 32'h0};           // ADDI -1
        vecs[2]  = '{32'h2826_0005, 9'h044, 3'b000, 2'b10, 32'h0000_0005, 32'h11, 32'h0, 1'b0, 32'h0};           // SLTI
        vecs[3]  = '{32'h3026_8000, 9'h047, 3'b000, 2'b10, 32'h0000_8000, 32'h11, 32'h0, 1'b0, 32'h0};           // ANDI zext
        vecs[4]  = '{32'h3426_8001, 9'h049, 3'b000, 2'b10, 32'h0000_8001, 32'h11, 32'h0, 1'b0, 32'h0};           // ORI zext
        vecs[5]  = '{32'h3826_FFFF, 9'h04B, 3'b000, 2'b10, 32'h0000_FFFF, 32'h11, 32'h0, 1'b0, 32'h0};           // XORI zext
        vecs[6]  = '{32'h3C06_1234, 9'h04C, 3'b000, 2'b10, 32'h0000_1234, 32'h0,  32'h0, 1'b0, 32'h0};           // LUI
        vecs[7]  = '{32'h8C26_0008, 9'h042, 3'b101, 2'b11, 32'h0000_0008, 32'h11, 32'h0, 1'b0, 32'h0};           // LW
        vecs[8]  = '{32'hAC22_FFFC, 9'h042, 3'b011, 2'b00, 32'hFFFF_FFFC, 32'h11, 32'h22, 1'b0, 32'h0};          // SW
        vecs[9]  = '{32'h1043_0010, 9'h000, 3'b000, 2'b00, 32'h0000_0010, 32'h22, 32'h22, 1'b1, 32'h0040_0050};  // BEQ taken
        vecs[10] = '{32'h1443_0010, 9'h000, 3'b000, 2'b00, 32'h0000_0010, 32'h22, 32'h22, 1'b0, 32'h0};          // BNE not taken
        vecs[11] = '{32'h1422_FFFE, 9'h000, 3'b000, 2'b00, 32'hFFFF_FFFE, 32'h11, 32'h22, 1'b1, 32'h0040_0008};  // BNE back
        vecs[12] = '{32'h0800_0100, 9'h000, 3'b000, 2'b00, 32'h0000_0100, 32'h0,  32'h0, 1'b1, 32'h0000_0400};   // J
        vecs[13] = '{32'h0C00_0200, 9'h120, 3'b000, 2'b10, 32'h0000_0200, 32'h0,  32'h0, 1'b1, 32'h0000_0800};   // JAL
        vecs[14] = '{32'h0080_0008, 9'h000, 3'b000, 2'b00, 32'h0000_0008, 32'h1000, 32'h0, 1'b1, 32'h0000_1000}; // JR r4
        vecs[15] = '{32'h0080_F809, 9'h0A0, 3'b000, 2'b10, 32'hFFFF_F809, 32'h1000, 32'h0, 1'b1, 32'h0000_1000}; // JALR
        vecs[16] = '{32'hFC22_1234, 9'h000, 3'b000, 2'b00, 32'h0000_1234, 32'h11, 32'h22, 1'b0, 32'h0};          // unknown
        vecs[17] = '{32'h0000_0000, 9'h000, 3'b000, 2'b00, 32'h0000_0000, 32'h0,  32'h0, 1'b0, 32'h0};           // NOP

        // ---------------- Reset state ----------------
        #2;
        chk("rst_exec", 32'(o_id_ex_exec), 32'h0);
        chk("rst_wb", 32'(o_id_ex_wrback), 32'h0);
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_pc_src", 32'(o_pc_src), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b1;
        step();
        $display("reset released");

        // ---------------- Writeback then use ----------------
        wr_reg(5'd1, 32'h1);
        i_instr = 32'h2024_0007;
        step();
        chk("wbuse_rs", o_id_ex_rs, 32'h1);
        chk("wbuse_sgext", o_id_ex_sgext, 32'h7);
        chk("wbuse_alusrc", 32'(o_id_ex_exec[6]), 32'h1);
        chk("wbuse_aluop", 32'(o_id_ex_exec[4:1]), 32'h1);
        chk("wbuse_wb", 32'(o_id_ex_wrback), 32'h2);
        $display("seq writeback-then-use rs=%h", o_id_ex_rs);
        nops(2);

        // ---------------- Bypass jump ----------------
        i_instr      = 32'h0140_0008;
        i_reg_dst    = 5'd10;
        i_wb_data    = 32'h8;
        i_wb_rf_webn = 1'b1;
        #2;
        chk("byp_pc_src", 32'(o_pc_src), 32'h1);
        chk("byp_tgt", o_pc_tgt, 32'h8);
        chk("byp_flush", 32'(o_flush), 32'h1);
        chk("byp_stall", 32'(o_stall), 32'h0);
        $display("seq bypass-jump tgt=%h", o_pc_tgt);
        step();
        i_wb_rf_webn = 1'b0;
        nops(2);

        // ---------------- Table ----------------
        wr_reg(5'd1, 32'h11);
        wr_reg(5'd2, 32'h22);
        wr_reg(5'd3, 32'h22);
        wr_reg(5'd4, 32'h1000);
        nops(2);
        i_pc = VPC;
        for (int v = 0; v < NVEC; v++) begin
            i_instr = vecs[v].instr;
            #2;
            chk("vec_stall", 32'(o_stall), 32'h0);
            chk("vec_pc_src", 32'(o_pc_src), 32'(vecs[v].src));
            chk("vec_flush", 32'(o_flush), 32'(vecs[v].src));
            if (vecs[v].src) chk("vec_tgt", o_pc_tgt, vecs[v].tgt);
            step();
            chk("vec_exec", 32'(o_id_ex_exec), 32'(vecs[v].exec));
            chk("vec_mem", 32'(o_id_ex_mem), 32'(vecs[v].mem));
            chk("vec_wb", 32'(o_id_ex_wrback), 32'(vecs[v].wb));
            chk("vec_sgext", o_id_ex_sgext, vecs[v].sgext);
            chk("vec_rs", o_id_ex_rs, vecs[v].rs_val);
            chk("vec_rt", o_id_ex_rt, vecs[v].rt_val);
            chk("vec_pc", o_id_ex_pc, VPC);
            chk("vec_rs_num", 32'(o_id_ex_rs_num), 32'(vecs[v].instr[25:21]));
            chk("vec_rt_num", 32'(o_id_ex_rt_num), 32'(vecs[v].instr[20:16]));
            chk("vec_rd_num", 32'(o_id_ex_rd_num), 32'(vecs[v].instr[15:11]));
            $display("vec %0d instr=%h exec=%h mem=%b wb=%b", v, vecs[v].instr,
                     o_id_ex_exec, o_id_ex_mem, o_id_ex_wrback);
            nops(2);
        end

        // ---------------- Load-use ----------------
        i_instr = 32'h8C41_0004;              // LW r1,4(r2)
        step();
        i_instr = 32'h0022_1820;              // ADD r3,r1,r2
        #2;
        chk("lu_stall", 32'(o_stall), 32'h1);
        chk("lu_pc_src", 32'(o_pc_src), 32'h0);
        step();
        chk("lu_bubble_exec", 32'(o_id_ex_exec), 32'h0);
        chk("lu_bubble_mem", 32'(o_id_ex_mem), 32'h0);
        chk("lu_bubble_wb", 32'(o_id_ex_wrback), 32'h0);
        #1;
        chk("lu_stall_released", 32'(o_stall), 32'h0);
        step();
        chk("lu_add_rs_num", 32'(o_id_ex_rs_num), 32'h1);
        chk("lu_add_rd_num", 32'(o_id_ex_rd_num), 32'h3);
        chk("lu_add_exec", 32'(o_id_ex_exec), 32'h080);
        chk("lu_add_wb", 32'(o_id_ex_wrback), 32'h2);
        $display("seq load-use done");
        nops(2);

        // ---------------- Branch after ADDI (forward from MEM) ----------------
        i_pc    = 32'h0040_0100;
        i_instr = 32'h2021_0005;              // ADDI r1,r1,5
        step();
        i_instr = 32'h1022_0081;              // BEQ r1,r2,0x81
        #2;
        chk("ba_stall", 32'(o_stall), 32'h1);
        chk("ba_pc_src_stalled", 32'(o_pc_src), 32'h0);
        step();
        i_mem_alu_data = 32'h22;
        #1;
        chk("ba_stall_released", 32'(o_stall), 32'h0);
        chk("ba_pc_src_eq", 32'(o_pc_src), 32'h1);
        chk("ba_tgt", o_pc_tgt, 32'h0040_0304);
        i_mem_alu_data = 32'h23;
        #1;
        chk("ba_pc_src_ne", 32'(o_pc_src), 32'h0);
        $display("seq branch-after-addi done");
        step();
        i_mem_alu_data = '0;
        nops(2);

        // ---------------- Branch after load (2 stalls, then bypass) ----------------
        i_pc    = 32'h0040_0200;
        i_instr = 32'h8C41_0004;              // LW r1,4(r2)
        step();
        i_instr = 32'h1423_0010;              // BNE r1,r3,0x10
        #2;
        chk("bl_stall1", 32'(o_stall), 32'h1);
        chk("bl_pc_src1", 32'(o_pc_src), 32'h0);
        step();
        #1;
        chk("bl_stall2", 32'(o_stall), 32'h1);
        chk("bl_pc_src2", 32'(o_pc_src), 32'h0);
        step();
        i_reg_dst    = 5'd1;
        i_wb_data    = 32'h22;
        i_wb_rf_webn = 1'b1;
        #1;
        chk("bl_stall3", 32'(o_stall), 32'h0);
        chk("bl_not_taken", 32'(o_pc_src), 32'h0);
        i_wb_data = 32'h55;
        #1;
        chk("bl_taken", 32'(o_pc_src), 32'h1);
        chk("bl_tgt", o_pc_tgt, 32'h0040_0240);
        $display("seq branch-after-load done");
        step();
        i_wb_rf_webn = 1'b0;
        nops(2);

        // ---------------- Reset mid-stall ----------------
        i_instr = 32'h8C41_0004;
        step();
        i_instr = 32'h0022_1820;
        #2;
        chk("rs_pre_stall", 32'(o_stall), 32'h1);
        i_rst = 1'b0;
        #1;
        chk("rs_stall", 32'(o_stall), 32'h0);
        chk("rs_pc_src", 32'(o_pc_src), 32'h0);
        chk("rs_flush", 32'(o_flush), 32'h0);
        chk("rs_exec", 32'(o_id_ex_exec), 32'h0);
        chk("rs_mem", 32'(o_id_ex_mem), 32'h0);
        chk("rs_wb", 32'(o_id_ex_wrback), 32'h0);
        chk("rs_pc", o_id_ex_pc, 32'h0);
        chk("rs_rs_num", 32'(o_id_ex_rt_num), 32'h0);
        i_rst   = 1'b1;
        i_instr = '0;
        step();
        chk("rs_nop_exec", 32'(o_id_ex_exec), 32'h0);
        chk("rs_nop_wb", 32'(o_id_ex_wrback), 32'h0);
        i_instr = 32'h0022_1820;
        #1;
        chk("rs_add_stall", 32'(o_stall), 32'h0);
        step();
        chk("rs_rf_cleared", o_id_ex_rt, 32'h0);
        chk("rs_add_rs_num", 32'(o_id_ex_rs_num), 32'h1);
        chk("rs_add_exec", 32'(o_id_ex_exec), 32'h080);
        $display("seq reset-mid-stall done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
